// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths, FSM states and command record for the memory arbiter
package mem_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester handshake and memory-side bus bundle
interface mem_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import mem_ctrl_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      mem_read;
    logic                      mem_write;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data_in;
    logic [DATA_W-1:0]         mem_data_out;

    // Arbiter side: accepts requests, drives the memory
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata,
               mem_read, mem_write, mem_addr, mem_data_in
    );

    // Environment side: requesters plus the memory itself
    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata,
               mem_read, mem_write, mem_addr, mem_data_in
    );

endinterface

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - combinational round-robin winner select
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id,
    output logic               grant_any
);

    // One extra bit holds ptr+offset before the wrap back into 0..NUM_REQ-1
    localparam logic [IDW:0] N_W = (IDW+1)'(NUM_REQ);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    // Scan from rr_ptr upward with wrap; first valid requester wins
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            idx = sum[IDW-1:0];
            if (!grant_any && req_valid[idx]) begin
                grant_any   = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin single-outstanding access sequencer for the 32x8 memory
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MEM_RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          busy
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Wait counter preload: WAIT_RD lasts MEM_RD_LAT cycles
    localparam logic [2:0] LAT_M1 = 3'(MEM_RD_LAT - 1);

    arb_state_e          state;
    arb_state_e          state_nx;
    mem_cmd_t            cmd;
    logic [IDW-1:0]      cmd_id;
    logic [IDW-1:0]      rr_ptr;
    logic [2:0]          wait_cnt;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic [NUM_REQ-1:0]  grant;
    logic [IDW-1:0]      grant_id;
    logic                grant_any;

    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    // Pick the winning requester's command fields out of the flat buses
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we    = bus.req_we[i];
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and all bus outputs, decoded from the current state
    always_comb begin
        state_nx        = state;
        bus.req_ready   = '0;
        bus.rsp_valid   = '0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_addr    = cmd.addr;
        bus.mem_data_in = cmd.wdata;
        bus.rsp_rdata   = rsp_rdata_q;
        busy            = (state != IDLE);
        case (state)
            IDLE: begin
                bus.req_ready = grant;
                if (grant_any) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_write = cmd.we;
                bus.mem_read  = !cmd.we;
                state_nx      = cmd.we ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (wait_cnt == 3'd0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    bus.rsp_valid[i] = (IDW'(i) == cmd_id);
                end
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Command latch, fairness pointer, read-latency counter and response data
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd         <= '0;
            cmd_id      <= '0;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            rsp_rdata_q <= '0;
        end else begin
            if (state == IDLE && grant_any) begin
                cmd.we    <= sel_we;
                cmd.addr  <= sel_addr;
                cmd.wdata <= sel_wdata;
                cmd_id    <= grant_id;
                rr_ptr    <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            if (state == ISSUE) begin
                wait_cnt <= LAT_M1;
            end else if (state == WAIT_RD && wait_cnt != 3'd0) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if (state == WAIT_RD && wait_cnt == 3'd0) begin
                rsp_rdata_q <= bus.mem_data_out;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin controller that shares the single 32x8 lab memory between NUM_REQ requesters.
- Sits between the requester ports and the memory side of the memory interface: mem_read, mem_write, mem_addr, mem_data_in and mem_data_out.
- Sequences one memory access at a time. Returns read data to the requester that issued the read.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MEM_RD_LAT, 1, cycles from the cycle mem_read is high to the cycle mem_data_out is valid (1..4).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_we  input  NUM_REQ  per-requester command: 1=write, 0=read.
- req_addr  input  NUM_REQ*5  per-requester address; requester i uses bits [5i+4:5i].
- req_wdata  input  NUM_REQ*8  per-requester write data; requester i uses bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot accept strobe.
- rsp_valid  output  NUM_REQ  one-hot read-response strobe.
- rsp_rdata  output  8  read data, qualified by rsp_valid.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  5  memory address.
- mem_data_in  output  8  memory write data.
- mem_data_out  input  8  memory read data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr = 0 (requester 0 has top priority).
  - Reset asserted mid-operation aborts the access.
  - No rsp_valid for the aborted access, and mem strobes drop the next cycle.
- Handshake: valid/ready.
  - Requester holds req_valid, req_we, req_addr and req_wdata stable until it sees req_ready.
  - A transfer occurs in a cycle where req_valid[i] && req_ready[i].
- req_ready is combinational. It is nonzero only in IDLE: exactly one bit, the RR winner among req_valid.
- RR selection: search starts at rr_ptr and wraps modulo NUM_REQ. On a grant to i, rr_ptr <= (i+1) mod NUM_REQ.
- Grant latches cmd {id, we, addr, wdata} into a register, then moves to ISSUE.
- FSM states and transitions:
  - IDLE: if any req_valid, grant -> ISSUE; else stay.
  - ISSUE: drive mem_addr/mem_data_in from cmd, and mem_write=we / mem_read=!we for exactly one cycle.
    - write -> IDLE.
    - read -> WAIT_RD, with wait counter = MEM_RD_LAT-1.
  - WAIT_RD: mem strobes 0, mem_addr held.
    - Counter decrements each cycle.
    - At count 0: rsp_rdata <= mem_data_out, then -> RESP.
  - RESP: rsp_valid[id]=1 for one cycle, rsp_rdata held -> IDLE.
- Timing with MEM_RD_LAT=1, grant in cycle T:
  - write: mem_write in T+1, next grant possible in T+2.
  - read: mem_read in T+1, sample in T+2, rsp_valid in T+3, next grant possible in T+4.
- rsp_rdata holds its last value outside RESP.
- mem_read and mem_write are never high together. Each is never high for more than one consecutive cycle per access.
- Simultaneous requests: exactly one is granted per IDLE cycle; the others wait, their req_ready stays 0.
- A requester dropping req_valid before ready is legal; nothing is latched for it.
- Only one access is outstanding at any time.

Decomposition:
- Package mem_ctrl_pkg holds:
  - ADDR_W=5 and DATA_W=8.
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} arb_state_e.
  - typedef struct packed {we, addr, wdata} mem_cmd_t.
- One sub-module, rr_arbiter: combinational winner select from (req_valid, rr_ptr) giving a one-hot grant plus a binary id, parameterised by NUM_REQ.
- The FSM, command register and response register stay in mem_arbiter.

Test Plan:
- Reset check: assert reset for 2 cycles mid-read (in WAIT_RD) -> all outputs 0 and busy=0 the cycle after reset; no rsp_valid ever appears for the aborted read; the next request from requester 0 is granted first.
- Single write then read, requester 1:
  - Write addr=5'd10, wdata=8'hA5 -> req_ready[1] in T, mem_write=1 with mem_addr=10 and mem_data_in=A5 in T+1 only.
  - Read addr=10 -> mem_read in T+1, rsp_valid=4'b0010 with rsp_rdata=8'hA5 in T+3.
- Round-robin fairness: all 4 requesters hold read requests continuously -> grant order 0,1,2,3,0,1; rsp_valid bits follow the same order; no requester is granted twice before the others.
- Mixed contention: requester 2 writes addr 3 = 8'h3C while requester 0 waits with a read of addr 3; rr_ptr=2 -> write is granted first, the read returns 8'h3C.
- Latency parameter: MEM_RD_LAT=3 with a memory model delaying data 3 cycles -> rsp_valid at T+5 with the correct data; busy stays high from T+1 through T+5.
- Full sweep: each requester in turn writes its own 8 addresses (all 32 locations) with data = addr^8'h5A, then reads them all back -> all 32 compare, and mem_read/mem_write are never high together.
